apb_master_slave: RTL and testbench

APB_MASTER_SLAVE -- requirements
Module: apb_master_slave

---
 rtl/apb_master_slave.sv | 124 ++++++++++++
 tb/tb_apb_master_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_slave.sv
// rtl/apb_master_slave.sv - APB master driving a 4-register APB slave over an observable internal bus
// Optional feature macro: APB_PSLVERR_EN (adds PSLVERR output for unmapped accesses)

module apb_master_slave #(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PWRITE_MASTER,
   input  logic [31:0] PADDR_MASTER,
   input  logic [31:0] PWDATA_MASTER,
   output logic [31:0] PRDATA_MASTER,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic        PREADY,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic [31:0] PRDATA
`ifdef APB_PSLVERR_EN
   ,
   output logic        PSLVERR
`endif
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_STATES);

   logic [1:0]  state;
   logic [3:0]  wait_cnt;
   logic [31:0] regs [0:3];
   logic        in_access;
   logic        enter_setup;
   logic        addr_mapped;
   logic [1:0]  reg_idx;

   // Bus phase decode: SETUP and ACCESS both select the slave, only ACCESS enables it.
   assign in_access   = (state == ST_ACCESS);
   assign PSEL        = (state == ST_SETUP) || (state == ST_ACCESS);
   assign PENABLE     = in_access;
   assign PREADY      = in_access && (wait_cnt == WAIT_LIMIT);

   // A new request is latched whenever the next state is SETUP.
   assign enter_setup = (state == ST_IDLE) || (in_access && PREADY);

   // Only the four word-aligned addresses 0x0..0xC reach a register.
   assign addr_mapped = (PADDR[31:4] == 28'd0) && (PADDR[1:0] == 2'b00);
   assign reg_idx     = PADDR[3:2];

   // Master FSM: IDLE only after reset, then SETUP/ACCESS back-to-back.
   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         state <= ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:   state <= ST_SETUP;
            ST_SETUP:  state <= ST_ACCESS;
            ST_ACCESS: if (PREADY) state <= ST_SETUP;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // Master request registers; held stable from SETUP through the end of ACCESS.
   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         PADDR  <= 32'd0;
         PWDATA <= 32'd0;
         PWRITE <= 1'b0;
      end else if (enter_setup) begin
         PADDR  <= PADDR_MASTER;
         PWDATA <= PWDATA_MASTER;
         PWRITE <= PWRITE_MASTER;
      end
   end

   // Slave wait-state counter: counts stalled ACCESS cycles, cleared outside them.
   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         wait_cnt <= 4'd0;
      end else if (in_access && !PREADY) begin
         wait_cnt <= wait_cnt + 4'd1;
      end else begin
         wait_cnt <= 4'd0;
      end
   end

   // Slave register file: written only on the completing ACCESS edge of a mapped write.
   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         for (int i = 0; i < 4; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (PSEL && PENABLE && PWRITE && PREADY && addr_mapped) begin
         regs[reg_idx] <= PWDATA;
      end
   end

   // Slave read mux: combinational during selected reads, zero otherwise.
   always_comb begin
      PRDATA = 32'd0;
      if (PSEL && !PWRITE && addr_mapped) begin
         PRDATA = regs[reg_idx];
      end
   end

   // Master read capture on the edge completing a read.
   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         PRDATA_MASTER <= 32'd0;
      end else if (in_access && PREADY && !PWRITE) begin
         PRDATA_MASTER <= PRDATA;
      end
   end

`ifdef APB_PSLVERR_EN
   // Error flag only on the completing cycle of an unmapped access.
   assign PSLVERR = PREADY && !addr_mapped;
`endif

endmodule

// File: tb/tb_apb_master_slave.sv
// tb/tb_apb_master_slave.sv - scoreboard bench for apb_master_slave (WAIT_STATES 0 and 2)

module tb_apb_master_slave;

   localparam int WS2 = 2;

   logic        PCLK = 1'b0;
   logic        PRESET;

   logic        m_write;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] d_prdata_master, d_paddr, d_pwdata, d_prdata;
   logic        d_psel, d_penable, d_pwrite, d_pready;

   logic        w2_write;
   logic [31:0] w2_addr, w2_wdata;
   logic [31:0] e_prdata_master, e_paddr, e_pwdata, e_prdata;
   logic        e_psel, e_penable, e_pwrite, e_pready;
`ifdef APB_PSLVERR_EN
   logic        d_pslverr, e_pslverr;
`endif

   always #5 PCLK = ~PCLK;

   apb_master_slave #(.WAIT_STATES(0)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .PWRITE_MASTER(m_write), .PADDR_MASTER(m_addr), .PWDATA_MASTER(m_wdata),
      .PRDATA_MASTER(d_prdata_master),
      .PSEL(d_psel), .PENABLE(d_penable), .PWRITE(d_pwrite), .PREADY(d_pready),
      .PADDR(d_paddr), .PWDATA(d_pwdata), .PRDATA(d_prdata)
`ifdef APB_PSLVERR_EN
      , .PSLVERR(d_pslverr)
`endif
   );

   apb_master_slave #(.WAIT_STATES(WS2)) dut_ws2 (
      .PCLK(PCLK), .PRESET(PRESET),
      .PWRITE_MASTER(w2_write), .PADDR_MASTER(w2_addr), .PWDATA_MASTER(w2_wdata),
      .PRDATA_MASTER(e_prdata_master),
      .PSEL(e_psel), .PENABLE(e_penable), .PWRITE(e_pwrite), .PREADY(e_pready),
      .PADDR(e_paddr), .PWDATA(e_pwdata), .PRDATA(e_prdata)
`ifdef APB_PSLVERR_EN
      , .PSLVERR(e_pslverr)
`endif
   );

   typedef struct {
      bit        wr;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [31:0] rdata;
      bit [31:0] pm;
      bit        err;
   } item_t;

   item_t     sb[$];
   item_t     mon_it;
   int        checks = 0;
   int        errors = 0;
   bit        stop = 0;
   bit        ws2_done = 0;
   bit        pend = 0;
   bit [31:0] pend_pm;
   int        setup_cnt = 0;
   int        acc_cnt = 0;

   // Reference model: register contents and last read value.
   bit [31:0] mdl [4];
   bit [31:0] mdl_pm;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic bit is_mapped(input bit [31:0] a);
      return (a < 32'd16) && (a % 4 == 0);
   endfunction

   function automatic bit [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0, 1, 2, 3: return 32'(4 * $urandom_range(0, 3));
         4:          return 32'h10 + 32'(4 * $urandom_range(0, 15));
         5:          return 32'(4 * $urandom_range(0, 3) + $urandom_range(1, 3));
         default:    return $urandom();
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mdl[i] = 32'd0;
      mdl_pm = 32'd0;
   endtask

   // Push the expected outcome, present the request, return once it has been latched.
   task automatic issue(input bit w, input bit [31:0] a, input bit [31:0] d, output int waited);
      item_t it;
      it.wr = w; it.addr = a; it.wdata = d; it.err = !is_mapped(a);
      if (w) begin
         it.rdata = 32'd0;
         if (is_mapped(a)) mdl[a / 4] = d;
      end else begin
         it.rdata = is_mapped(a) ? mdl[a / 4] : 32'd0;
         mdl_pm = it.rdata;
      end
      it.pm = mdl_pm;
      sb.push_back(it);
      m_write = w; m_addr = a; m_wdata = d;
      waited = 0;
      do begin
         @(negedge PCLK);
         waited++;
      end while (!(d_psel && !d_penable) && waited < 50);
      if (!(d_psel && !d_penable)) chk("setup_timeout", 32'(waited), 32'd0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_psel",    32'(d_psel), 32'd0);
      chk("rst_penable", 32'(d_penable), 32'd0);
      chk("rst_pwrite",  32'(d_pwrite), 32'd0);
      chk("rst_pready",  32'(d_pready), 32'd0);
      chk("rst_paddr",   d_paddr, 32'd0);
      chk("rst_pwdata",  d_pwdata, 32'd0);
      chk("rst_prdata_master", d_prdata_master, 32'd0);
   endtask

   // Monitor: phase timing and scoreboard comparison on each completed transfer.
   always @(negedge PCLK) begin
      if (!PRESET) begin
         sb.delete();
         pend = 0;
         setup_cnt = 0;
         acc_cnt = 0;
      end else if (!stop) begin
         if (pend) begin
            chk("prdata_master", d_prdata_master, pend_pm);
            pend = 0;
         end
         if (!d_psel) begin
            setup_cnt = 0;
            acc_cnt = 0;
         end else if (!d_penable) begin
            setup_cnt++;
            acc_cnt = 0;
         end else begin
            if (acc_cnt == 0) chk("setup_len", 32'(setup_cnt), 32'd1);
            setup_cnt = 0;
            acc_cnt++;
            if (d_pready) begin
               chk("access_len", 32'(acc_cnt), 32'd1);
               acc_cnt = 0;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_transfer: got addr 0x%08h expected none", d_paddr);
               end else begin
                  mon_it = sb.pop_front();
                  chk("paddr",  d_paddr, mon_it.addr);
                  chk("pwrite", 32'(d_pwrite), 32'(mon_it.wr));
                  if (mon_it.wr) chk("pwdata", d_pwdata, mon_it.wdata);
                  chk("prdata", d_prdata, mon_it.rdata);
`ifdef APB_PSLVERR_EN
                  chk("pslverr", 32'(d_pslverr), 32'(mon_it.err));
`endif
                  pend = 1;
                  pend_pm = mon_it.pm;
               end
            end
         end
      end
   end

   // WAIT_STATES=2 instance: write 0x4, then read it and time the ACCESS phase.
   initial begin
      int n;
      w2_write = 1'b1; w2_addr = 32'h4; w2_wdata = 32'h13122023;
      @(posedge PRESET);
      n = 0;
      do begin @(negedge PCLK); n++; end while (!(e_psel && !e_penable) && n < 20);
      chk("ws2_first_setup", 32'(e_psel && !e_penable), 32'd1);
      w2_write = 1'b0;
      @(negedge PCLK);
      n = 0;
      while (!(e_psel && !e_penable) && n < 20) begin @(negedge PCLK); n++; end
      chk("ws2_read_setup", 32'(e_psel && !e_penable), 32'd1);
      chk("ws2_read_pwrite", 32'(e_pwrite), 32'd0);
      for (int k = 0; k < WS2 + 1; k++) begin
         @(negedge PCLK);
         chk("ws2_penable", 32'(e_penable), 32'd1);
         chk("ws2_pready", 32'(e_pready), 32'(k == WS2));
         if (k == WS2) chk("ws2_prdata", e_prdata, 32'h13122023);
      end
      @(negedge PCLK);
      chk("ws2_next_setup", 32'(e_psel && !e_penable), 32'd1);
      chk("ws2_prdata_master", e_prdata_master, 32'h13122023);
      ws2_done = 1;
   end

   // Main stimulus.
   initial begin
      int        n;
      bit        w;
      bit [31:0] a;
      PRESET = 1'b0;
      m_write = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
      model_reset();
      repeat (3) @(negedge PCLK);
      check_reset_outputs();

      @(negedge PCLK);
      PRESET = 1'b1;
      issue(1, 32'h0, 32'd24, n);
      chk("first_setup_delay", 32'(n), 32'd1);
      issue(1, 32'h4, 32'h13122023, n);
      issue(1, 32'h8, 32'h53686B61, n);
      issue(1, 32'hC, 32'h44656E69, n);
      issue(0, 32'h0, 32'd0, n);
      issue(0, 32'h4, 32'd0, n);
      issue(0, 32'h8, 32'd0, n);
      issue(0, 32'hC, 32'd0, n);
      issue(1, 32'h10, 32'hDEADBEEF, n);
      issue(0, 32'h10, 32'd0, n);
      issue(0, 32'h0, 32'd0, n);

      for (int i = 0; i < 150; i++) begin
         w = 1'($urandom_range(0, 1));
         a = rand_addr();
         issue(w, a, $urandom(), n);
         if (w && $urandom_range(0, 2) == 0) issue(0, a, $urandom(), n);
      end

      // Abort a write mid-ACCESS with reset.
      issue(1, 32'h8, 32'h55, n);
      @(posedge PCLK);
      #2 PRESET = 1'b0;
      model_reset();
      @(negedge PCLK);
      @(negedge PCLK);
      check_reset_outputs();
      PRESET = 1'b1;
      issue(0, 32'h8, 32'd0, n);
      chk("setup_after_reset", 32'(n), 32'd1);
      issue(0, 32'h0, 32'd0, n);
      issue(0, 32'h4, 32'd0, n);
      issue(0, 32'hC, 32'd0, n);

      @(negedge PCLK);
      @(negedge PCLK);
      #1 stop = 1;
      n = 0;
      while (!ws2_done && n < 100) begin @(negedge PCLK); n++; end
      chk("ws2_done", 32'(ws2_done), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
